// File: rtl/mem_responder_if.sv
// Request/response bundle between a streaming compute master and mem_responder.
// The master owns MEMA/MEMRE/MEMWE/MEMD; the responder owns MEMQ/MEMBUSY/MEMDONE/MEMERR.
interface mem_responder_if #(
    parameter int WA = 32,
    parameter int WD = 32
);
    // Handshake: the master raises MEMRE or MEMWE (level) and holds it until it
    // sees MEMBUSY; the responder captures the request on the first IDLE edge,
    // keeps MEMBUSY high through the single-cycle MEMDONE pulse, and ignores
    // MEMRE/MEMWE while busy. MEMQ is valid in the MEMDONE cycle of a read.
    logic [WA-1:0] MEMA;
    logic          MEMRE;
    logic          MEMWE;
    logic [WD-1:0] MEMD;
    logic [WD-1:0] MEMQ;
    logic          MEMBUSY;
    logic          MEMDONE;
    logic          MEMERR;

    modport master (
        output MEMA, MEMRE, MEMWE, MEMD,
        input  MEMQ, MEMBUSY, MEMDONE, MEMERR
    );

    modport slave (
        input  MEMA, MEMRE, MEMWE, MEMD,
        output MEMQ, MEMBUSY, MEMDONE, MEMERR
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder backed by an internal word array.
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write completion counters RDCNT/WRCNT.
module mem_responder #(
    parameter int WA         = 32,
    parameter int WD         = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_SHIFT = 5,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RSTX,
    mem_responder_if.slave bus,
    output logic [1:0]  dbg_state
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0] RDCNT,
    output logic [15:0] WRCNT
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    // Captured request
    logic [AW-1:0] idx_q;
    logic          inr_q;
    logic [WD-1:0] data_q;
    logic          wr_q;

    logic [WD-1:0] q_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [WD-1:0] mem [DEPTH];

    logic [WA-1:0] idx_w;
    logic          inr_w;
    logic          capture;
    logic          commit;
    logic          release_busy;

    assign idx_w = bus.MEMA >> ADDR_SHIFT;
    assign inr_w = (idx_w < WA'(DEPTH));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        commit       = 1'b0;
        release_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.MEMWE || bus.MEMRE) begin
                    capture = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                release_busy = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write wins when both request lines are high; the read is simply dropped.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            idx_q  <= '0;
            inr_q  <= 1'b0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (capture) begin
            idx_q  <= idx_w[AW-1:0];
            inr_q  <= inr_w;
            data_q <= bus.MEMD;
            wr_q   <= bus.MEMWE;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            q_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (capture) begin
                busy_q <= 1'b1;
            end else if (release_busy) begin
                busy_q <= 1'b0;
            end
            done_q <= commit;
            if (commit && !wr_q) begin
                q_q <= inr_q ? mem[idx_q] : '0;
            end
            if (commit && !inr_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // Array has no reset; reset forces IDLE, so an aborted write never commits.
    always_ff @(posedge CLK) begin
        if (commit && wr_q && inr_q) begin
            mem[idx_q] <= data_q;
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rdcnt_q;
    logic [15:0] wrcnt_q;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            rdcnt_q <= 16'd0;
            wrcnt_q <= 16'd0;
        end else if (commit) begin
            if (wr_q) begin
                if (wrcnt_q != 16'hFFFF) wrcnt_q <= wrcnt_q + 16'd1;
            end else begin
                if (rdcnt_q != 16'hFFFF) rdcnt_q <= rdcnt_q + 16'd1;
            end
        end
    end

    assign RDCNT = rdcnt_q;
    assign WRCNT = wrcnt_q;
`endif

    assign bus.MEMQ    = q_q;
    assign bus.MEMBUSY = busy_q;
    assign bus.MEMDONE = done_q;
    assign bus.MEMERR  = err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the MEMA/MEMRE/MEMWE/MEMD/MEMQ/MEMBUSY/MEMDONE request interface used by our streaming compute masters (vector add and similar).
- Services one read or write at a time from an internal word array, with a fixed, parameterised access latency.
- Drives the BUSY/DONE handshake that masters poll. Sits between any such master and a behavioural or FPGA-inferred RAM.

Parameters:
- WA, 32, address width.
- WD, 32, data width.
- DEPTH, 4096, number of WD-bit words in the array.
- ADDR_SHIFT, 5, right shift applied to MEMA to form the word index (masters step addresses by 32).
- LATENCY, 2, wait cycles between request capture and DONE; legal range 1..15.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RSTX  input  1  asynchronous active-low reset.
- MEMA  input  WA  request address.
- MEMRE  input  1  read request, level.
- MEMWE  input  1  write request, level.
- MEMD  input  WD  write data.
- MEMQ  output  WD  read data, valid in the cycle MEMDONE=1, held until the next read completes.
- MEMBUSY  output  1  high from request capture through the DONE cycle.
- MEMDONE  output  1  one-cycle completion pulse.
- MEMERR  output  1  sticky out-of-range flag.

Behaviour:
- Reset (RSTX=0, asynchronous):
  - State IDLE; MEMQ=0, MEMBUSY=0, MEMDONE=0, MEMERR=0.
  - Latched address, data and op are cleared. Any pending write is discarded.
  - Array contents are not reset.
- Index = MEMA >> ADDR_SHIFT. Low ADDR_SHIFT bits are ignored. Index is in range iff it is < DEPTH.
- State machine: IDLE -> WAIT -> DONE -> IDLE.
- IDLE, at edge T with MEMWE or MEMRE high:
  - Latch index, MEMD and op.
  - MEMBUSY<=1; load wait counter with LATENCY; go to WAIT.
  - If MEMWE and MEMRE are both high, the write wins and the read is dropped.
- WAIT: counter decrements each edge. On the edge where counter==1 (edge T+LATENCY) the block performs the access and goes to DONE:
  - Write: array[index]<=data when in range.
  - Read: MEMQ<=array[index] when in range, else MEMQ<=0.
  - MEMDONE<=1.
  - Out-of-range access of either kind: MEMERR<=1, array unchanged.
- DONE (edge T+LATENCY+1): MEMDONE<=0, MEMBUSY<=0, return to IDLE.
- Latency summary: MEMBUSY is high for exactly LATENCY+1 cycles; MEMDONE rises LATENCY cycles after the capture edge.
- MEMRE/MEMWE are ignored in WAIT and DONE. Masters hold the request until they see MEMBUSY and drop it well before IDLE is re-entered, so a held request is never double-serviced.
- A request seen on the first IDLE cycle after DONE is accepted immediately. There is no forced gap; a master waiting on !MEMBUSY sees IDLE one cycle after DONE.
- A write is visible to a read accepted on any later cycle. There is no read-during-write hazard, since only one access is in flight.
- MEMQ does not change on write completions.
- MEMERR clears only on reset.
- Reset asserted in WAIT or DONE aborts the access. An uncommitted write leaves the array unchanged.

Optional Feature:
- Macro MEM_RESPONDER_STATS_EN.
- When defined:
  - Adds outputs RDCNT[15:0] and WRCNT[15:0], reset to 0.
  - Each increments by 1 on the edge its access completes (the edge MEMDONE rises), whether the access is in range or out of range.
  - Each saturates at 0xFFFF.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset -> MEMQ=0, MEMBUSY=0, MEMDONE=0, MEMERR=0. Assert RSTX low mid-cycle -> outputs clear without waiting for a clock edge.
- LATENCY=2: write MEMA=0x40, MEMD=0xDEADBEEF, held until BUSY; then read 0x40 -> BUSY high 3 cycles per access, DONE at T+2, MEMQ=0xDEADBEEF in the DONE cycle.
- Connect the vector-add master:
  - Preload index 0=5 and index 1024=7.
  - Expected: index 2048 becomes 12; reads of MEMA 0 and 0x8000 return 5 and 7.
  - MEMERR stays 0 through cnt=SIZE, since index 3072 is < DEPTH.
- MEMRE=MEMWE=1 at 0x20 with MEMD=0x1234 -> write performed, index 1=0x1234, MEMQ unchanged; RDCNT=0, WRCNT=1 with the macro defined.
- Read MEMA=0x20000 (index 4096) -> MEMQ=0 at DONE, MEMERR=1 and still 1 after ten further in-range accesses.
- Write 0x55 to 0x60, assert RSTX low during WAIT -> after reset, a read of 0x60 returns the prior value. A second RE pulse during BUSY is ignored: DONE count = 1.
